// File: rtl/mem_bus_responder.sv
// mem_bus_responder: services core fetch/read/write requests either as
// little-endian byte beats on the external memory port or as a single
// halfword transaction on the IO port, returning one-cycle done pulses.
module mem_bus_responder #(
  parameter int unsigned RV = 16,
  parameter int unsigned VA = RV
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic [VA-1:1] pc,
  input  logic          ifetch,
  output logic          idone,
  output logic [RV-1:0] insn,
  input  logic [VA-1:1] addr,
  input  logic [1:0]    rstrobe,
  output logic          rdone,
  output logic [RV-1:0] rdata,
  input  logic [1:0]    wmask,
  input  logic [RV-1:0] wdata,
  output logic          wdone,
  input  logic          io_access,
  output logic          mem_req,
  output logic          mem_we,
  output logic [VA-1:0] mem_addr,
  output logic [7:0]    mem_wdata,
  input  logic [7:0]    mem_rdata,
  input  logic          mem_ack,
  output logic          io_req,
  output logic          io_we,
  output logic [VA-1:1] io_addr,
  output logic [RV-1:0] io_wdata,
  input  logic [RV-1:0] io_rdata,
  input  logic          io_ack
);

  typedef enum logic [2:0] {IDLE, BEAT0, BEAT1, IOWAIT, RESP} state_t;
  typedef enum logic [1:0] {K_FETCH, K_READ, K_WRITE} kind_t;

  state_t        state, next_state;
  kind_t         kind_q;
  logic [VA-1:1] cmd_addr;
  logic [RV-1:0] cmd_data;
  logic          cmd_half;
  logic          cmd_odd;
  logic [7:0]    lo_byte;
  logic [RV-1:0] insn_q;
  logic [RV-1:0] rdata_q;

  logic data_req;
  assign data_req = (|wmask) || (|rstrobe);

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= next_state;
  end

  // Next-state: requests are only looked at in IDLE; RESP always returns to IDLE
  always_comb begin
    next_state = state;
    unique case (state)
      IDLE: begin
        if (data_req)    next_state = io_access ? IOWAIT : BEAT0;
        else if (ifetch) next_state = BEAT0;
      end
      BEAT0:   if (mem_ack) next_state = cmd_half ? BEAT1 : RESP;
      BEAT1:   if (mem_ack) next_state = RESP;
      IOWAIT:  if (io_ack)  next_state = RESP;
      RESP:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Command latch on acceptance and capture of returned data
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      kind_q   <= K_FETCH;
      cmd_addr <= '0;
      cmd_data <= '0;
      cmd_half <= 1'b0;
      cmd_odd  <= 1'b0;
      lo_byte  <= '0;
      insn_q   <= '0;
      rdata_q  <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (|wmask) begin
            kind_q   <= K_WRITE;
            cmd_addr <= addr;
            cmd_data <= wdata;
            cmd_half <= &wmask;
            cmd_odd  <= (wmask == 2'b10);
          end else if (|rstrobe) begin
            kind_q   <= K_READ;
            cmd_addr <= addr;
            cmd_half <= &rstrobe;
            cmd_odd  <= (rstrobe == 2'b10);
          end else if (ifetch) begin
            kind_q   <= K_FETCH;
            cmd_addr <= pc;
            cmd_half <= 1'b1;
            cmd_odd  <= 1'b0;
          end
        end
        BEAT0: begin
          if (mem_ack) begin
            lo_byte <= mem_rdata;
            if (kind_q == K_READ && !cmd_half) rdata_q <= {8'h00, mem_rdata};
          end
        end
        BEAT1: begin
          if (mem_ack) begin
            if (kind_q == K_FETCH)     insn_q  <= {mem_rdata, lo_byte};
            else if (kind_q == K_READ) rdata_q <= {mem_rdata, lo_byte};
          end
        end
        IOWAIT: begin
          if (io_ack && kind_q == K_READ) rdata_q <= io_rdata;
        end
        default: ;
      endcase
    end
  end

  // Outputs decoded from state so an asynchronous reset drops them at once
  always_comb begin
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    io_req    = 1'b0;
    io_we     = 1'b0;
    io_addr   = '0;
    io_wdata  = '0;
    idone     = 1'b0;
    rdone     = 1'b0;
    wdone     = 1'b0;
    unique case (state)
      BEAT0: begin
        mem_req   = 1'b1;
        mem_we    = (kind_q == K_WRITE);
        mem_addr  = {cmd_addr, cmd_odd};
        mem_wdata = cmd_odd ? cmd_data[15:8] : cmd_data[7:0];
      end
      BEAT1: begin
        mem_req   = 1'b1;
        mem_we    = (kind_q == K_WRITE);
        mem_addr  = {cmd_addr, 1'b1};
        mem_wdata = cmd_data[15:8];
      end
      IOWAIT: begin
        io_req   = 1'b1;
        io_we    = (kind_q == K_WRITE);
        io_addr  = cmd_addr;
        io_wdata = cmd_data;
      end
      RESP: begin
        idone = (kind_q == K_FETCH);
        rdone = (kind_q == K_READ);
        wdone = (kind_q == K_WRITE);
      end
      default: ;
    endcase
  end

  assign insn  = insn_q;
  assign rdata = rdata_q;

endmodule

// File: tb/tb_mem_bus_responder.sv
// Directed bench for mem_bus_responder with a byte memory / IO responder
// and scoreboard queues for beats, IO handshakes and done pulses.
module tb_mem_bus_responder;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [15:1] pc;
  logic        ifetch;
  logic        idone;
  logic [15:0] insn;
  logic [15:1] addr;
  logic [1:0]  rstrobe;
  logic        rdone;
  logic [15:0] rdata;
  logic [1:0]  wmask;
  logic [15:0] wdata;
  logic        wdone;
  logic        io_access;
  logic        mem_req;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata = '0;
  logic        mem_ack = 1'b0;
  logic        io_req;
  logic        io_we;
  logic [15:1] io_addr;
  logic [15:0] io_wdata;
  logic [15:0] io_rdata = '0;
  logic        io_ack = 1'b0;

  mem_bus_responder #(.RV(16), .VA(16)) dut (
    .clk(clk), .reset_n(reset_n),
    .pc(pc), .ifetch(ifetch), .idone(idone), .insn(insn),
    .addr(addr), .rstrobe(rstrobe), .rdone(rdone), .rdata(rdata),
    .wmask(wmask), .wdata(wdata), .wdone(wdone), .io_access(io_access),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .io_req(io_req), .io_we(io_we), .io_addr(io_addr), .io_wdata(io_wdata),
    .io_rdata(io_rdata), .io_ack(io_ack)
  );

  always #5 clk = ~clk;

  typedef struct { logic [15:0] a; logic we; logic [7:0] wd; } beat_t;
  typedef struct { logic [15:1] a; logic we; logic [15:0] wd; } io_t;
  typedef struct { logic [2:0] kind; logic [15:0] data; } done_t;

  localparam logic [2:0] D_FETCH = 3'b100;
  localparam logic [2:0] D_READ  = 3'b010;
  localparam logic [2:0] D_WRITE = 3'b001;

  beat_t exp_beats[$];
  io_t   exp_io[$];
  done_t exp_done[$];

  logic [7:0]  mem [0:255];
  int          mem_delay = 0;
  int          io_delay  = 0;
  logic [15:0] io_value  = '0;
  int          wcnt = 0;
  int          iocnt = 0;

  int   n_assert = 0;
  int   n_fail   = 0;
  logic [2:0] last_d = '0;
  logic [2:0] prev_d = '0;
  logic mem_seen = 1'b0;

  // Memory and IO responders: ack after the programmed number of wait cycles
  always @(negedge clk) begin
    if (mem_req && wcnt >= mem_delay) begin
      mem_ack   <= 1'b1;
      mem_rdata <= mem[mem_addr[7:0]];
      wcnt      <= 0;
    end else if (mem_req) begin
      mem_ack <= 1'b0;
      wcnt    <= wcnt + 1;
    end else begin
      mem_ack <= 1'b0;
      wcnt    <= 0;
    end
    if (io_req && iocnt >= io_delay) begin
      io_ack   <= 1'b1;
      io_rdata <= io_value;
      iocnt    <= 0;
    end else if (io_req) begin
      io_ack <= 1'b0;
      iocnt  <= iocnt + 1;
    end else begin
      io_ack <= 1'b0;
      iocnt  <= 0;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    beat_t b;
    io_t   o;
    done_t e;
    logic [2:0] d;
    @(negedge clk);
    #1;
    d = {idone, rdone, wdone};
    if (mem_req) mem_seen = 1'b1;
    if (mem_req && mem_ack) begin
      check("beat_expected", exp_beats.size() != 0, 1);
      if (exp_beats.size() != 0) begin
        b = exp_beats.pop_front();
        check("beat_addr", mem_addr, b.a);
        check("beat_we", mem_we, b.we);
        if (b.we) check("beat_wdata", mem_wdata, b.wd);
      end
    end
    if (io_req && io_ack) begin
      check("io_expected", exp_io.size() != 0, 1);
      if (exp_io.size() != 0) begin
        o = exp_io.pop_front();
        check("io_addr", io_addr, o.a);
        check("io_we", io_we, o.we);
        if (o.we) check("io_wdata", io_wdata, o.wd);
      end
    end
    if (d != 3'b000) begin
      check("done_onehot", $countones(d), 1);
      check("done_gap", prev_d != 3'b000, 0);
      check("done_expected", exp_done.size() != 0, 1);
      if (exp_done.size() != 0) begin
        e = exp_done.pop_front();
        check("done_kind", d, e.kind);
        if (e.kind == D_FETCH) check("insn", insn, e.data);
        if (e.kind == D_READ)  check("rdata", rdata, e.data);
      end
    end
    prev_d = d;
    last_d = d;
  endtask

  task automatic wait_done(input string tag, input int exp_lat);
    int   n;
    logic got;
    n = 0;
    got = 1'b0;
    while (!got && n < 40) begin
      tick();
      n++;
      if (last_d != 3'b000) got = 1'b1;
    end
    check({tag, "_done_seen"}, got, 1);
    if (got) check({tag, "_latency"}, n, exp_lat);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic push_beat(input logic [15:0] a, input logic we, input logic [7:0] wd);
    beat_t b;
    b.a = a; b.we = we; b.wd = wd;
    exp_beats.push_back(b);
  endtask

  task automatic push_done(input logic [2:0] k, input logic [15:0] dat);
    done_t e;
    e.kind = k; e.data = dat;
    exp_done.push_back(e);
  endtask

  task automatic push_io(input logic [15:1] a, input logic we, input logic [15:0] wd);
    io_t o;
    o.a = a; o.we = we; o.wd = wd;
    exp_io.push_back(o);
  endtask

  initial begin
    int   n;
    logic found;
    reset_n = 1'b0; pc = '0; ifetch = 1'b0; addr = '0; rstrobe = '0;
    wmask = '0; wdata = '0; io_access = 1'b0;
    mem[8'h20] = 8'h34; mem[8'h21] = 8'h12;
    mem[8'h22] = 8'h78; mem[8'h23] = 8'h56;
    mem[8'h81] = 8'hA5;

    // reset state
    idle(2);
    check("rst_mem_req", mem_req, 0);
    check("rst_io_req", io_req, 0);
    check("rst_dones", {idone, rdone, wdone}, 0);
    check("rst_insn", insn, 0);
    check("rst_rdata", rdata, 0);
    check("rst_mem_bus", {mem_we, mem_addr, mem_wdata}, 0);
    check("rst_io_bus", {io_we, io_addr, io_wdata}, 0);
    reset_n = 1'b1;
    idle(2);

    // halfword fetch, zero wait
    pc = 15'h0010; ifetch = 1'b1;
    push_beat(16'h0020, 1'b0, 8'h00);
    push_beat(16'h0021, 1'b0, 8'h00);
    push_done(D_FETCH, 16'h1234);
    wait_done("fetch", 3);
    ifetch = 1'b0;
    idle(3);

    // odd byte read with two wait states
    addr = 15'h0040; rstrobe = 2'b10; mem_delay = 2;
    push_beat(16'h0081, 1'b0, 8'h00);
    push_done(D_READ, 16'h00A5);
    wait_done("byte_read", 4);
    rstrobe = '0; mem_delay = 0;
    idle(3);

    // even byte write; core inputs change after acceptance
    addr = 15'h0003; wmask = 2'b01; wdata = 16'h5A5A;
    push_beat(16'h0006, 1'b1, 8'h5A);
    push_done(D_WRITE, 16'h0000);
    tick();
    wdata = 16'h0000; addr = 15'h007F;
    wait_done("byte_write", 1);
    // back-to-back halfword write: accepted one cycle after the pulse
    addr = 15'h0003; wmask = 2'b11; wdata = 16'hBEEF;
    push_beat(16'h0006, 1'b1, 8'hEF);
    push_beat(16'h0007, 1'b1, 8'hBE);
    push_done(D_WRITE, 16'h0000);
    wait_done("half_write", 4);
    wmask = '0;
    idle(3);

    // IO read, one wait state, memory port untouched
    mem_seen = 1'b0;
    addr = 15'h0123; rstrobe = 2'b11; io_access = 1'b1;
    io_value = 16'hC0DE; io_delay = 1;
    push_io(15'h0123, 1'b0, 16'h0000);
    push_done(D_READ, 16'hC0DE);
    wait_done("io_read", 3);
    check("io_no_mem", mem_seen, 0);
    // write and fetch raised together: write wins, fetch stays pending
    rstrobe = '0; io_access = 1'b0; io_delay = 0;
    wmask = 2'b11; wdata = 16'h1357; addr = 15'h0050;
    ifetch = 1'b1; pc = 15'h0011;
    push_beat(16'h00A0, 1'b1, 8'h57);
    push_beat(16'h00A1, 1'b1, 8'h13);
    push_done(D_WRITE, 16'h0000);
    push_beat(16'h0022, 1'b0, 8'h00);
    push_beat(16'h0023, 1'b0, 8'h56);
    push_done(D_FETCH, 16'h5678);
    wait_done("prio_write", 4);
    wmask = '0;
    wait_done("prio_fetch", 4);
    ifetch = 1'b0;
    idle(3);

    // IO byte write: data presented as-is
    io_access = 1'b1; wmask = 2'b01; wdata = 16'hAB12; addr = 15'h0200;
    push_io(15'h0200, 1'b1, 16'hAB12);
    push_done(D_WRITE, 16'h0000);
    wait_done("io_write", 2);
    io_access = 1'b0; wmask = '0;
    idle(3);

    // reset during BEAT1 of a fetch
    mem_delay = 5; pc = 15'h0010; ifetch = 1'b1;
    push_beat(16'h0020, 1'b0, 8'h00);
    found = 1'b0;
    n = 0;
    while (!found && n < 30) begin
      tick();
      n++;
      if (mem_req && mem_addr[0]) found = 1'b1;
    end
    check("beat1_reached", found, 1);
    reset_n = 1'b0;
    #1;
    check("async_mem_req", mem_req, 0);
    check("async_idone", idone, 0);
    idle(2);
    mem_delay = 0;
    reset_n = 1'b1;
    push_beat(16'h0020, 1'b0, 8'h00);
    push_beat(16'h0021, 1'b0, 8'h00);
    push_done(D_FETCH, 16'h1234);
    wait_done("refetch", 3);
    ifetch = 1'b0;
    idle(4);

    check("beats_left", exp_beats.size(), 0);
    check("io_left", exp_io.size(), 0);
    check("done_left", exp_done.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
